// File: rtl/and_stream_pkg.sv
// Shared types and helpers for the AND stream gate: the operation select
// encoding, the per-entry result record and the bitwise operation itself.
package and_stream_pkg;

    // Widest operand the block supports; results are computed at this width
    // and then narrowed to the configured operand width.
    localparam int MAX_W = 64;

    // Operation select, sampled together with the operands.
    typedef enum logic [1:0] {
        AND_OP  = 2'd0,
        NAND_OP = 2'd1,
        ANDN_OP = 2'd2,
        RSVD_OP = 2'd3
    } mode_t;

    // One buffered result: the data word plus its reduction-AND, so the
    // all-ones flag never has to be recomputed on the output side.
    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic             all_ones;
    } result_t;

    // Bitwise operation selected by the mode; the reserved code behaves as
    // a plain AND and is reported separately through the sticky error flag.
    function automatic logic [MAX_W-1:0] apply_op(
        input mode_t            m,
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] z
    );
        logic [MAX_W-1:0] r;
        case (m)
            AND_OP:  r = x & z;
            NAND_OP: r = ~(x & z);
            ANDN_OP: r = x & ~z;
            default: r = x & z;
        endcase
        return r;
    endfunction

    // Mask with the low w bits set; a shift by the full width wraps to zero,
    // so subtracting one still yields all ones when w equals MAX_W.
    function automatic logic [MAX_W-1:0] low_mask(input int w);
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

endpackage

// File: rtl/and_stream_fifo.sv
// Result buffer for the AND stream gate: a small circular FIFO whose
// write-side ready flag is registered so it never depends on the reader.
module and_stream_fifo
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     can_write,
    output logic                     has_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_next;
    logic [PW-1:0]    rd_ptr_next;
    logic [LW-1:0]    level_next;
    logic             do_wr;
    logic             do_rd;

    assign has_data = (level != '0);
    assign do_wr    = wr_en && can_write;
    assign do_rd    = rd_en && has_data;

    // The head is only meaningful while something is held; otherwise drive
    // zeros so stale storage never leaks onto the output.
    assign rd_data  = has_data ? mem[rd_ptr] : '0;

    // Next pointer and occupancy values; pointers wrap explicitly at the
    // last entry and the level moves only when exactly one side transfers.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        level_next  = level;
        if (do_wr) begin
            wr_ptr_next = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_next = (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Storage array; no reset needed because the level gates what is visible.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer, occupancy and registered ready state; reset empties the buffer
    // and holds the write side closed until the first edge after release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            can_write <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            level     <= level_next;
            can_write <= (level_next < LW'(DEPTH));
        end
    end

endmodule

// File: rtl/and_stream_gate.sv
// AND stream gate: takes operand pairs through a valid/ready handshake,
// applies the selected bitwise operation and queues the results in order.
module and_stream_gate
    import and_stream_pkg::*;
#(
    parameter int AND_INPUTS_WIDTH = 8,
    parameter int DEPTH            = 4
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [AND_INPUTS_WIDTH-1:0]   a,
    input  logic [AND_INPUTS_WIDTH-1:0]   b,
    input  logic [1:0]                    mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [AND_INPUTS_WIDTH-1:0]   y,
    output logic                          y_all_ones,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          err
);

    localparam int W = AND_INPUTS_WIDTH;

    // Bits above the configured width are forced high so the reduction-AND
    // over the full record only reflects the live result bits.
    localparam logic [MAX_W-1:0] PAD_MASK = ~low_mask(W);

    mode_t            op_mode;
    logic [MAX_W-1:0] raw;
    result_t          entry;
    logic [W:0]       wr_word;
    logic [W:0]       rd_word;
    logic             accept;
    logic             can_write;
    logic             has_data;

    // Decode the operation and build the buffer entry {all_ones, data}.
    always_comb begin
        op_mode        = mode_t'(mode);
        raw            = apply_op(op_mode, MAX_W'(a), MAX_W'(b));
        entry.data     = raw | PAD_MASK;
        entry.all_ones = &entry.data;
        wr_word        = {entry.all_ones, entry.data[W-1:0]};
    end

    assign in_ready   = can_write;
    assign accept     = in_valid && can_write;
    assign out_valid  = has_data;
    assign y          = rd_word[W-1:0];
    assign y_all_ones = rd_word[W];

    // Sticky flag recording that a reserved-mode pair was ever accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept && (op_mode == RSVD_OP)) begin
            err <= 1'b1;
        end
    end

    and_stream_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (in_valid),
        .wr_data   (wr_word),
        .rd_en     (out_ready),
        .rd_data   (rd_word),
        .can_write (can_write),
        .has_data  (has_data),
        .level     (level)
    );

endmodule

// File: tb/tb_and_stream_gate.sv
// Testbench for and_stream_gate: table-driven operation vectors plus
// hand-written backpressure, streaming, reserved-mode and reset sequences,
// all checked through an in-order scoreboard of expected results.
module tb_and_stream_gate;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          y_all_ones;
    logic [LW-1:0] level;
    logic          err;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [W:0] sb_q [$];
    logic [W:0] cur_exp;
    bit         exp_ready;
    bit         exp_err;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_y;
        logic         exp_ones;
    } vec_t;

    vec_t vecs [8];

    and_stream_gate #(
        .AND_INPUTS_WIDTH (W),
        .DEPTH            (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .y_all_ones (y_all_ones),
        .level      (level),
        .err        (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference operation, returning {all_ones, result}.
    function automatic logic [W:0] model_result(input logic [1:0] m,
                                                input logic [W-1:0] x,
                                                input logic [W-1:0] z);
        logic [W-1:0] r;
        case (m)
            2'd1:    r = ~(x & z);
            2'd2:    r = x & ~z;
            default: r = x & z;
        endcase
        return {&r, r};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [1:0] m,
                                  input logic [W-1:0] x, input logic [W-1:0] z,
                                  input logic ordy, input logic [W:0] exp);
        in_valid  = v;
        mode      = m;
        a         = x;
        b         = z;
        out_ready = ordy;
        cur_exp   = exp;
    endtask

    // One clock: check outputs against the model, update the scoreboard for
    // the handshakes that will happen at the coming edge, then advance.
    task automatic cycle(output bit accepted);
        bit         popped;
        logic [W:0] head;
        #1;
        check_output("in_ready",  64'(in_ready),  64'(exp_ready));
        check_output("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        check_output("level",     64'(level),     64'(sb_q.size()));
        check_output("err",       64'(err),       64'(exp_err));
        if (sb_q.size() != 0) begin
            head = sb_q[0];
            check_output("y",          64'(y),          64'(head[W-1:0]));
            check_output("y_all_ones", 64'(y_all_ones), 64'(head[W]));
        end else begin
            check_output("y_idle",          64'(y),          64'(0));
            check_output("y_all_ones_idle", 64'(y_all_ones), 64'(0));
        end
        accepted = rst && in_valid && exp_ready;
        popped   = rst && out_ready && (sb_q.size() != 0);
        if (popped) void'(sb_q.pop_front());
        if (accepted) begin
            sb_q.push_back(cur_exp);
            if (mode == 2'd3) exp_err = 1'b1;
        end
        if (!rst) begin
            sb_q.delete();
            exp_err = 1'b0;
        end
        exp_ready = rst && (sb_q.size() < DEPTH);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit           acc;
        bit           got;
        logic [W-1:0] x;
        logic [W-1:0] z;
        logic [1:0]   m;

        vecs[0] = '{2'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{2'd1, 8'hFF, 8'h00, 8'hFF, 1'b1};
        vecs[2] = '{2'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[3] = '{2'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[4] = '{2'd1, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[5] = '{2'd2, 8'hAA, 8'h55, 8'hAA, 1'b0};
        vecs[6] = '{2'd1, 8'h0F, 8'hF0, 8'hFF, 1'b1};
        vecs[7] = '{2'd2, 8'h00, 8'h00, 8'h00, 1'b0};

        rst       = 1'b0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        apply_stimulus(1'b0, 2'd0, '0, '0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] reset state");
        cycle(acc);
        rst = 1'b1;
        cycle(acc);

        $display("[TB] operation table");
        foreach (vecs[i]) begin
            apply_stimulus(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, 1'b1,
                           {vecs[i].exp_ones, vecs[i].exp_y});
            cycle(acc);
        end
        apply_stimulus(1'b0, 2'd0, '0, '0, 1'b1, '0);
        cycle(acc);
        cycle(acc);

        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) begin
            x = 8'(i * 37 + 5);
            apply_stimulus(1'b1, 2'd0, x, 8'hFF, 1'b0, model_result(2'd0, x, 8'hFF));
            cycle(acc);
        end
        apply_stimulus(1'b1, 2'd1, 8'h55, 8'h0F, 1'b0, model_result(2'd1, 8'h55, 8'h0F));
        cycle(acc);
        check_output("level_full", 64'(level), 64'(DEPTH));
        out_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(acc);
            if (acc) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL fifth_accept: got none, expected accept within 8 cycles");
        end
        apply_stimulus(1'b0, 2'd0, '0, '0, 1'b1, '0);
        for (int k = 0; k < 10; k++) begin
            if (sb_q.size() == 0) break;
            cycle(acc);
        end
        cycle(acc);

        $display("[TB] streaming");
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom_range(0, 255));
            z = 8'($urandom_range(0, 255));
            m = 2'($urandom_range(0, 2));
            apply_stimulus(1'b1, m, x, z, 1'b1, model_result(m, x, z));
            cycle(acc);
        end
        apply_stimulus(1'b0, 2'd0, '0, '0, 1'b1, '0);
        cycle(acc);
        cycle(acc);

        $display("[TB] reserved mode");
        apply_stimulus(1'b1, 2'd3, 8'hAA, 8'hFF, 1'b1, {1'b0, 8'hAA});
        cycle(acc);
        apply_stimulus(1'b0, 2'd0, '0, '0, 1'b1, '0);
        cycle(acc);
        cycle(acc);
        cycle(acc);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            x = 8'(8'hF0 + i);
            apply_stimulus(1'b1, 2'd0, x, 8'h3F, 1'b0, model_result(2'd0, x, 8'h3F));
            cycle(acc);
        end
        apply_stimulus(1'b0, 2'd0, '0, '0, 1'b0, '0);
        rst = 1'b0;
        cycle(acc);
        rst = 1'b1;
        cycle(acc);
        out_ready = 1'b1;
        cycle(acc);
        cycle(acc);
        cycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
